multi_channel_dispenser: RTL and testbench
==========================================

# multi_channel_dispenser

Parametrised multi-outlet dispenser controller: one keypad/switch entry front end drives CHANNEL_COUNT independent valve channels, each metering its own volume concurrently. Sits between the board's button edge detectors/switches and the valve relays and seven-segment displays, and supersedes the single-outlet dispenser.

## Interface
- CHANNEL_COUNT, 2, number of independent valves (1..8)
- DIGIT_COUNT, 4, maximum decimal digits of an entered volume (1..6)
- CYCLES_PER_ML, 50000, clock cycles per millilitre of flow (1 ms at 50 MHz)
- SWITCH_COUNT, 10, digit-select switches; switch i means digit i
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- switches  in  SWITCH_COUNT  digit selection; lowest set index wins
- add_pulse, ok_pulse, cancel_pulse, select_pulse  in  1 each  single-cycle strobes from upstream edge detectors
- selected  out  clog2(CHANNEL_COUNT) (min 1)  channel addressed by ok/cancel
- entry_ml  out  4*DIGIT_COUNT  volume being keyed in
- remaining_ml  out  CHANNEL_COUNT*4*DIGIT_COUNT  packed per-channel remaining volume
- valve_open  out  CHANNEL_COUNT  active-high relay drive
- done  out  CHANNEL_COUNT  one-cycle pulse when a channel completes naturally
- bcd  out  4*DIGIT_COUNT  display digits, digit 0 = units

## Operation
- Reset: entry_ml=0, digit count=0, selected=0, all remaining_ml=0, valve_open=0, done=0, bcd=0.
- Strobe priority when coincident: cancel > ok > select > add; lower-priority strobes that cycle are ignored.
- add: if no switch set or digit count = DIGIT_COUNT, ignored. Else entry_ml <= entry_ml*10 + d. Digit count increments only when the result is nonzero (leading zeros are free).
- select: selected <= selected+1, wrapping CHANNEL_COUNT-1 -> 0. Entry preserved.
- ok: if entry_ml > 0 and selected channel idle, the channel loads remaining = entry_ml, clears its prescaler and opens its valve; entry_ml and digit count clear. Otherwise ignored, entry kept.
- cancel: if entry_ml != 0, clear entry and digit count only. Else if selected channel is dispensing, force remaining=0 and close the valve, no done pulse. Else no effect.
- Channel FSM, per channel: IDLE -> (load) -> DISPENSING -> (remaining reaches 0 or abort) -> IDLE. In DISPENSING a prescaler counts 0..CYCLES_PER_ML-1; at the terminal count, remaining decrements. When decrement produces 0, the valve closes and done pulses in the same cycle.
- Channels run fully independently. Selecting away from a dispensing channel does not affect it.
- Display source: entry_ml if nonzero or selected channel idle, else selected channel's remaining. Conversion is a sequential double-dabble, restarted whenever the source value changes; bcd holds the last complete result until the new one finishes.

## Timing
- ok at cycle t -> valve_open[ch] high from t+1; entry_ml=0 at t+1.
- Volume V -> valve high for exactly V*CYCLES_PER_ML cycles; done asserted on the cycle valve_open falls.
- cancel abort at t -> valve low from t+1.
- add at t -> entry_ml updated at t+1.
- bcd valid at most 4*DIGIT_COUNT+2 cycles after the source changes.
- Reset mid-dispense: all valves close immediately (asynchronous) and there is no done pulse.
- ok to a channel on the same cycle it finishes: channel still DISPENSING -> ok ignored.

## Structure
- Package dispenser_pkg: channel state encoding (IDLE, DISPENSING), amount_width(DIGIT_COUNT)=4*DIGIT_COUNT, and the clog2 helper.
- Sub-module dispense_channel (prescaler, remaining counter, FSM, load/abort inputs, valve/done outputs), instantiated CHANNEL_COUNT times by generate.
- Double-dabble converter stays inline in the top.

## Test plan
- CYCLES_PER_ML=4. Add switch 2, 5 -> entry 25; ok on ch0 -> valve_open[0] high exactly 100 cycles, done[0] one pulse, remaining 0.
- Add 0,0,1,2,3,4 -> entry 1234, fifth nonzero add ignored. Cancel -> 0. Cancel again with idle channel -> no change.
- Start ch0 with 10 ml; select; start ch1 with 3 ml -> both valves overlap, ch1 done after 12 cycles, ch0 after 40.
- ch1 dispensing, entry empty, cancel at cycle 5 -> valve_open[1] low next cycle, no done, remaining 0.
- ok and add on the same cycle -> ok wins, digit not appended. ok on a busy channel -> ignored, entry kept.
- Assert reset mid-dispense on two channels -> valves 0 immediately, all outputs at reset values; bcd settles to 0000 within 18 cycles.

Source files
------------

// File: rtl/dispenser_pkg.sv
// Shared types and sizing helpers for the multi-outlet dispenser.
package dispenser_pkg;

  typedef enum logic [0:0] {
    CH_IDLE       = 1'b0,
    CH_DISPENSING = 1'b1
  } ch_state_e;

  // Width of a volume held as DIGIT_COUNT packed decimal digits.
  function automatic int amount_width(input int digit_count);
    return 4 * digit_count;
  endfunction

  // Bits needed to index `value` items, never less than one.
  function automatic int clog2_min1(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dispense_channel.sv
// One valve channel: loads a volume, meters it out via a per-ml prescaler,
// and pulses done on natural completion (an abort closes silently).
module dispense_channel
  import dispenser_pkg::*;
#(
  parameter int AMOUNT_WIDTH  = 16,
  parameter int CYCLES_PER_ML = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    abort,
  input  logic [AMOUNT_WIDTH-1:0] load_ml,
  output logic                    valve_open,
  output logic                    done,
  output logic [AMOUNT_WIDTH-1:0] remaining_ml,
  output logic                    busy
);

  localparam int PW = clog2_min1(CYCLES_PER_ML);
  localparam logic [PW-1:0] TERMINAL = PW'(CYCLES_PER_ML - 1);

  ch_state_e               state_r, state_next_s;
  logic [PW-1:0]           prescale_r, prescale_next_s;
  logic [AMOUNT_WIDTH-1:0] remaining_r, remaining_next_s;
  logic                    valve_r, valve_next_s;
  logic                    done_r, done_next_s;

  // Next-state logic: abort beats the natural terminal decrement.
  always_comb begin
    state_next_s     = state_r;
    prescale_next_s  = prescale_r;
    remaining_next_s = remaining_r;
    valve_next_s     = valve_r;
    done_next_s      = 1'b0;
    case (state_r)
      CH_IDLE: begin
        if (load) begin
          state_next_s     = CH_DISPENSING;
          prescale_next_s  = {PW{1'b0}};
          remaining_next_s = load_ml;
          valve_next_s     = 1'b1;
        end else begin
          valve_next_s = 1'b0;
        end
      end
      CH_DISPENSING: begin
        if (abort) begin
          state_next_s     = CH_IDLE;
          prescale_next_s  = {PW{1'b0}};
          remaining_next_s = {AMOUNT_WIDTH{1'b0}};
          valve_next_s     = 1'b0;
        end else if (prescale_r == TERMINAL) begin
          prescale_next_s  = {PW{1'b0}};
          remaining_next_s = remaining_r - AMOUNT_WIDTH'(1);
          if (remaining_r == AMOUNT_WIDTH'(1)) begin
            state_next_s = CH_IDLE;
            valve_next_s = 1'b0;
            done_next_s  = 1'b1;
          end else begin
            valve_next_s = 1'b1;
          end
        end else begin
          prescale_next_s = prescale_r + PW'(1);
        end
      end
      default: begin
        state_next_s = CH_IDLE;
        valve_next_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= CH_IDLE;
      prescale_r  <= {PW{1'b0}};
      remaining_r <= {AMOUNT_WIDTH{1'b0}};
      valve_r     <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      prescale_r  <= prescale_next_s;
      remaining_r <= remaining_next_s;
      valve_r     <= valve_next_s;
      done_r      <= done_next_s;
    end
  end

  assign valve_open   = valve_r;
  assign done         = done_r;
  assign remaining_ml = remaining_r;
  assign busy         = (state_r == CH_DISPENSING);

endmodule

// File: rtl/multi_channel_dispenser.sv
// Keypad entry front end shared by CHANNEL_COUNT valve channels, with a
// sequential double-dabble feeding the seven-segment digits.
module multi_channel_dispenser
  import dispenser_pkg::*;
#(
  parameter int CHANNEL_COUNT = 2,
  parameter int DIGIT_COUNT   = 4,
  parameter int CYCLES_PER_ML = 50000,
  parameter int SWITCH_COUNT  = 10
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [SWITCH_COUNT-1:0]                          switches,
  input  logic                                             add_pulse,
  input  logic                                             ok_pulse,
  input  logic                                             cancel_pulse,
  input  logic                                             select_pulse,
  output logic [clog2_min1(CHANNEL_COUNT)-1:0]             selected,
  output logic [amount_width(DIGIT_COUNT)-1:0]             entry_ml,
  output logic [CHANNEL_COUNT*amount_width(DIGIT_COUNT)-1:0] remaining_ml,
  output logic [CHANNEL_COUNT-1:0]                         valve_open,
  output logic [CHANNEL_COUNT-1:0]                         done,
  output logic [amount_width(DIGIT_COUNT)-1:0]             bcd
);

  localparam int AW  = amount_width(DIGIT_COUNT);
  localparam int SW  = clog2_min1(CHANNEL_COUNT);
  localparam int DCW = clog2_min1(DIGIT_COUNT + 1);
  localparam int CW  = clog2_min1(AW + 1);

  logic [AW-1:0]            entry_r, entry_next_s, appended_s;
  logic [DCW-1:0]           digit_count_r, digit_count_next_s;
  logic [SW-1:0]            selected_r, selected_next_s;
  logic [3:0]               digit_s;
  logic                     digit_valid_s;
  logic [CHANNEL_COUNT-1:0] load_s, abort_s, busy_s;
  logic                     sel_busy_s;
  logic [AW-1:0]            remaining_s [CHANNEL_COUNT];

  logic [AW-1:0]            source_s, source_r;
  logic [2*AW-1:0]          dd_r, dd_adj_s, dd_shift_s;
  logic [CW-1:0]            bits_left_r;
  logic [AW-1:0]            bcd_r;

  // Lowest set switch selects the digit.
  always_comb begin
    digit_s       = 4'd0;
    digit_valid_s = |switches;
    for (int i = SWITCH_COUNT - 1; i >= 0; i--) begin
      digit_s = switches[i] ? 4'(i) : digit_s;
    end
    appended_s = (entry_r << 3) + (entry_r << 1) + AW'(digit_s);
  end

  // Strobe decode in priority order cancel > ok > select > add.
  always_comb begin
    entry_next_s       = entry_r;
    digit_count_next_s = digit_count_r;
    selected_next_s    = selected_r;
    load_s             = {CHANNEL_COUNT{1'b0}};
    abort_s            = {CHANNEL_COUNT{1'b0}};
    sel_busy_s         = busy_s[selected_r];
    if (cancel_pulse) begin
      if (entry_r != {AW{1'b0}}) begin
        entry_next_s       = {AW{1'b0}};
        digit_count_next_s = {DCW{1'b0}};
      end else if (sel_busy_s) begin
        abort_s[selected_r] = 1'b1;
      end else begin
        abort_s = {CHANNEL_COUNT{1'b0}};
      end
    end else if (ok_pulse) begin
      if ((entry_r != {AW{1'b0}}) && !sel_busy_s) begin
        load_s[selected_r] = 1'b1;
        entry_next_s       = {AW{1'b0}};
        digit_count_next_s = {DCW{1'b0}};
      end else begin
        entry_next_s = entry_r;
      end
    end else if (select_pulse) begin
      if (selected_r == SW'(CHANNEL_COUNT - 1)) begin
        selected_next_s = {SW{1'b0}};
      end else begin
        selected_next_s = selected_r + SW'(1);
      end
    end else if (add_pulse) begin
      if (digit_valid_s && (digit_count_r != DCW'(DIGIT_COUNT))) begin
        entry_next_s = appended_s;
        // Leading zeros do not consume a digit position.
        if (appended_s != {AW{1'b0}}) begin
          digit_count_next_s = digit_count_r + DCW'(1);
        end else begin
          digit_count_next_s = digit_count_r;
        end
      end else begin
        entry_next_s = entry_r;
      end
    end else begin
      entry_next_s = entry_r;
    end
  end

  // Entry and channel-select registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_r       <= {AW{1'b0}};
      digit_count_r <= {DCW{1'b0}};
      selected_r    <= {SW{1'b0}};
    end else begin
      entry_r       <= entry_next_s;
      digit_count_r <= digit_count_next_s;
      selected_r    <= selected_next_s;
    end
  end

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_channel
    dispense_channel #(
      .AMOUNT_WIDTH (AW),
      .CYCLES_PER_ML(CYCLES_PER_ML)
    ) u_channel (
      .clock       (clock),
      .reset       (reset),
      .load        (load_s[g]),
      .abort       (abort_s[g]),
      .load_ml     (entry_r),
      .valve_open  (valve_open[g]),
      .done        (done[g]),
      .remaining_ml(remaining_s[g]),
      .busy        (busy_s[g])
    );
    assign remaining_ml[g*AW +: AW] = remaining_s[g];
  end

  // Display source plus one add-3-then-shift double-dabble step.
  always_comb begin
    if ((entry_r != {AW{1'b0}}) || !sel_busy_s) begin
      source_s = entry_r;
    end else begin
      source_s = remaining_s[selected_r];
    end
    dd_adj_s = dd_r;
    for (int d = 0; d < DIGIT_COUNT; d++) begin
      dd_adj_s[AW + 4*d +: 4] = (dd_r[AW + 4*d +: 4] >= 4'd5) ?
                                dd_r[AW + 4*d +: 4] + 4'd3 : dd_r[AW + 4*d +: 4];
    end
    dd_shift_s = dd_adj_s << 1;
  end

  // Converter sequencing: restart on any source change, publish on last shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      source_r    <= {AW{1'b0}};
      dd_r        <= {(2*AW){1'b0}};
      bits_left_r <= {CW{1'b0}};
      bcd_r       <= {AW{1'b0}};
    end else if (source_s != source_r) begin
      source_r    <= source_s;
      dd_r        <= {{AW{1'b0}}, source_s};
      bits_left_r <= CW'(AW);
    end else if (bits_left_r != {CW{1'b0}}) begin
      dd_r        <= dd_shift_s;
      bits_left_r <= bits_left_r - CW'(1);
      if (bits_left_r == CW'(1)) begin
        bcd_r <= dd_shift_s[2*AW-1:AW];
      end else begin
        bcd_r <= bcd_r;
      end
    end else begin
      bcd_r <= bcd_r;
    end
  end

  assign selected = selected_r;
  assign entry_ml = entry_r;
  assign bcd      = bcd_r;

endmodule

// File: tb/tb_multi_channel_dispenser.sv
// Directed bench for multi_channel_dispenser at 4 cycles per millilitre.
module tb_multi_channel_dispenser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  switches = 10'd0;
  logic        add_pulse = 1'b0, ok_pulse = 1'b0, cancel_pulse = 1'b0, select_pulse = 1'b0;
  logic [0:0]  selected;
  logic [15:0] entry_ml, bcd;
  logic [31:0] remaining_ml;
  logic [1:0]  valve_open, done;

  int tests_run = 0;
  int tests_failed = 0;
  int high_cnt [2];
  int done_cnt [2];
  int bad_done;
  logic [1:0] prev_valve;
  logic overlap_seen;

  multi_channel_dispenser #(
    .CHANNEL_COUNT(2), .DIGIT_COUNT(4), .CYCLES_PER_ML(4), .SWITCH_COUNT(10)
  ) dut (
    .clock(clock), .reset(reset), .switches(switches),
    .add_pulse(add_pulse), .ok_pulse(ok_pulse),
    .cancel_pulse(cancel_pulse), .select_pulse(select_pulse),
    .selected(selected), .entry_ml(entry_ml), .remaining_ml(remaining_ml),
    .valve_open(valve_open), .done(done), .bcd(bcd)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      high_cnt[c] = 0;
      done_cnt[c] = 0;
    end
    bad_done     = 0;
    overlap_seen = 1'b0;
    prev_valve   = valve_open;
  endtask

  // Advance to the next falling edge and log valve/done behaviour.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      for (int c = 0; c < 2; c++) begin
        high_cnt[c] += int'(valve_open[c]);
        done_cnt[c] += int'(done[c]);
        if (done[c] && (valve_open[c] || !prev_valve[c])) bad_done++;
      end
      if (valve_open == 2'b11) overlap_seen = 1'b1;
      prev_valve = valve_open;
    end
  endtask

  task automatic strobe(input logic a, input logic o, input logic c, input logic s, input int digit);
    switches     = (digit >= 0) ? 10'(1 << digit) : 10'd0;
    add_pulse    = a;
    ok_pulse     = o;
    cancel_pulse = c;
    select_pulse = s;
    tick(1);
    switches     = 10'd0;
    add_pulse    = 1'b0;
    ok_pulse     = 1'b0;
    cancel_pulse = 1'b0;
    select_pulse = 1'b0;
  endtask

  initial begin
    clear_counts();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tick(1);
    check_value("rst_entry", 32'(entry_ml), 32'd0);
    check_value("rst_sel", 32'(selected), 32'd0);
    check_value("rst_remaining", remaining_ml, 32'd0);
    check_value("rst_valve", 32'(valve_open), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_bcd", 32'(bcd), 32'd0);

    // 25 ml on channel 0
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 2);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 5);
    check_value("entry_25", 32'(entry_ml), 32'd25);
    tick(18);
    check_value("bcd_25", 32'(bcd), 32'h0025);
    clear_counts();
    strobe(1'b0, 1'b1, 1'b0, 1'b0, -1);
    check_value("ok_valve0", 32'(valve_open[0]), 32'd1);
    check_value("ok_entry_clr", 32'(entry_ml), 32'd0);
    tick(119);
    check_value("ch0_high_100", 32'(high_cnt[0]), 32'd100);
    check_value("ch0_done_once", 32'(done_cnt[0]), 32'd1);
    check_value("done_timing", 32'(bad_done), 32'd0);
    check_value("ch0_remaining0", 32'(remaining_ml[15:0]), 32'd0);

    // Leading zeros, digit limit, cancel
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_value("leading_zero", 32'(entry_ml), 32'd0);
    for (int d = 1; d <= 4; d++) strobe(1'b1, 1'b0, 1'b0, 1'b0, d);
    check_value("entry_1234", 32'(entry_ml), 32'd1234);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 5);
    check_value("fifth_ignored", 32'(entry_ml), 32'd1234);
    tick(18);
    check_value("bcd_1234", 32'(bcd), 32'h1234);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, -1);
    check_value("cancel_entry", 32'(entry_ml), 32'd0);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, -1);
    check_value("cancel_idle_entry", 32'(entry_ml), 32'd0);
    check_value("cancel_idle_valve", 32'(valve_open), 32'd0);
    tick(18);
    check_value("bcd_back_0", 32'(bcd), 32'd0);

    // Overlapping channels: 10 ml on ch0, 3 ml on ch1
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 0);
    clear_counts();
    strobe(1'b0, 1'b1, 1'b0, 1'b0, -1);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, -1);
    check_value("select_to_1", 32'(selected), 32'd1);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 3);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, -1);
    tick(60);
    check_value("ovl_ch0_high", 32'(high_cnt[0]), 32'd40);
    check_value("ovl_ch1_high", 32'(high_cnt[1]), 32'd12);
    check_value("ovl_ch0_done", 32'(done_cnt[0]), 32'd1);
    check_value("ovl_ch1_done", 32'(done_cnt[1]), 32'd1);
    check_value("ovl_seen", 32'(overlap_seen), 32'd1);

    // Abort ch1 mid-dispense
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 5);
    clear_counts();
    strobe(1'b0, 1'b1, 1'b0, 1'b0, -1);
    tick(4);
    strobe(1'b0, 1'b0, 1'b1, 1'b0, -1);
    check_value("abort_valve1", 32'(valve_open[1]), 32'd0);
    check_value("abort_remaining1", 32'(remaining_ml[31:16]), 32'd0);
    tick(30);
    check_value("abort_no_done", 32'(done_cnt[1]), 32'd0);
    check_value("abort_high5", 32'(high_cnt[1]), 32'd5);

    // Busy channel ignores ok; ok beats add
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 9);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, -1);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 7);
    strobe(1'b0, 1'b1, 1'b0, 1'b0, -1);
    check_value("busy_ok_entry", 32'(entry_ml), 32'd7);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, -1);
    check_value("select_wrap", 32'(selected), 32'd0);
    strobe(1'b1, 1'b1, 1'b0, 1'b0, 3);
    check_value("okadd_entry", 32'(entry_ml), 32'd0);
    check_value("okadd_valves", 32'(valve_open), 32'd3);
    check_value("okadd_rem0", 32'(remaining_ml[15:0]), 32'd7);

    // Asynchronous reset mid-dispense
    tick(3);
    #2 reset = 1'b1;
    #1;
    check_value("arst_valves", 32'(valve_open), 32'd0);
    check_value("arst_done", 32'(done), 32'd0);
    check_value("arst_remaining", remaining_ml, 32'd0);
    check_value("arst_entry", 32'(entry_ml), 32'd0);
    check_value("arst_sel", 32'(selected), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    clear_counts();
    tick(18);
    check_value("arst_bcd", 32'(bcd), 32'd0);
    check_value("arst_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
    check_value("arst_valves_stay", 32'(valve_open), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
